// File: rtl/rf_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_if
//  Description : Bundles the issue, ALU-result, LSU-result, RF write-port and
//                status signals of rf_writeback.
//                slave  : the writeback block (consumes issue/results, drives
//                         ready, the RF write port and status).
//                master : whoever drives issue requests and results.
//                Signals:
//                  iss_valid/iss_rd/iss_rs1/iss_rs2 -> iss_ready
//                  alu_valid/alu_rd/alu_data        -> alu_ready
//                  lsu_valid/lsu_rd/lsu_data        -> lsu_ready
//                  rf_wen/rf_waddr/rf_wdata          RF write port
//                  busy_vec, wb_count, err           status
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_writeback_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                       iss_valid;
  logic [ADDR_WIDTH-1:0]      iss_rd;
  logic [ADDR_WIDTH-1:0]      iss_rs1;
  logic [ADDR_WIDTH-1:0]      iss_rs2;
  logic                       iss_ready;

  logic                       alu_valid;
  logic [ADDR_WIDTH-1:0]      alu_rd;
  logic [DATA_WIDTH-1:0]      alu_data;
  logic                       alu_ready;

  logic                       lsu_valid;
  logic [ADDR_WIDTH-1:0]      lsu_rd;
  logic [DATA_WIDTH-1:0]      lsu_data;
  logic                       lsu_ready;

  logic                       rf_wen;
  logic [ADDR_WIDTH-1:0]      rf_waddr;
  logic [DATA_WIDTH-1:0]      rf_wdata;

  logic [2**ADDR_WIDTH-1:0]   busy_vec;
  logic [CNT_WIDTH-1:0]       wb_count;
  logic                       err;

  modport slave (
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    output iss_ready,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output busy_vec, wb_count, err
  );

  modport master (
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  iss_ready,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  busy_vec, wb_count, err
  );
endinterface
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback
//  Description : Write side of the integer register file. Arbitrates ALU and
//                LSU results (LSU first) onto the single registered RF write
//                port and keeps a per-register busy scoreboard that stalls
//                issue on RAW/WAW hazards until the pending write lands.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                bus  - rf_writeback_if.slave (issue, results, RF write
//                       port, busy_vec, wb_count, sticky err)
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rf_writeback_if.slave  bus
);

  localparam int c_num_regs = 2**ADDR_WIDTH;

  // Register 0 is hard-wired, so only entries 1..N-1 carry state.
  logic [c_num_regs-1:1]   r_busy;
  logic [c_num_regs-1:0]   w_busy_vec;

  logic                    r_wen;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [CNT_WIDTH-1:0]    r_count;
  logic                    r_err;

  logic                    w_acc_valid;
  logic [ADDR_WIDTH-1:0]   w_acc_rd;
  logic [DATA_WIDTH-1:0]   w_acc_data;
  logic                    w_acc_write;
  logic                    w_iss_ready;
  logic                    w_iss_fire;
  logic [c_num_regs-1:0]   w_set;
  logic [c_num_regs-1:0]   w_clr;

  assign w_busy_vec = {r_busy, 1'b0};

  assign w_iss_ready = ~w_busy_vec[bus.iss_rs1] & ~w_busy_vec[bus.iss_rs2]
                     & ~w_busy_vec[bus.iss_rd];
  assign w_iss_fire  = bus.iss_valid & w_iss_ready & (bus.iss_rd != '0);

  // LSU results are never back-pressured; the ALU waits whenever the LSU
  // claims the write port.
  always_comb begin
    w_acc_valid = 1'b0;
    w_acc_rd    = '0;
    w_acc_data  = '0;
    if (bus.lsu_valid) begin
      w_acc_valid = 1'b1;
      w_acc_rd    = bus.lsu_rd;
      w_acc_data  = bus.lsu_data;
    end else if (bus.alu_valid) begin
      w_acc_valid = 1'b1;
      w_acc_rd    = bus.alu_rd;
      w_acc_data  = bus.alu_data;
    end
  end

  // Results for x0 are consumed but produce no write.
  assign w_acc_write = w_acc_valid & (w_acc_rd != '0);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_iss_fire) begin
      w_set[bus.iss_rd] = 1'b1;
    end
    // The busy bit drops at the end of the cycle the write is presented.
    if (r_wen) begin
      w_clr[r_waddr] = 1'b1;
    end
  end

  // A set and clear of the same register on one edge leaves it busy: the
  // new owner's write is still outstanding.
  generate
    for (genvar gi = 1; gi < c_num_regs; gi++) begin : g_busy
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_busy[gi] <= 1'b0;
        end else begin
          r_busy[gi] <= w_set[gi] | (r_busy[gi] & ~w_clr[gi]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wen <= w_acc_write;
      // Address/data hold their last value when nothing is written.
      if (w_acc_write) begin
        r_waddr <= w_acc_rd;
        r_wdata <= w_acc_data;
      end
      r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, r_wen};
      // A result for a register nobody is waiting on is flagged, but the
      // write still goes through.
      if (w_acc_write & ~w_busy_vec[w_acc_rd]) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.iss_ready = w_iss_ready;
  assign bus.alu_ready = ~bus.lsu_valid;
  assign bus.lsu_ready = 1'b1;
  assign bus.rf_wen    = r_wen;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.busy_vec  = w_busy_vec;
  assign bus.wb_count  = r_count;
  assign bus.err       = r_err;

endmodule
`default_nettype wire
